// File: rtl/musb_timer_defines.sv
// rtl/musb_timer_defines.sv - register map, bit indices and bus FSM states shared by musb_timer
package musb_timer_defines;

  localparam logic [1:0] TIMER_CTRL    = 2'd0;
  localparam logic [1:0] TIMER_COUNT   = 2'd1;
  localparam logic [1:0] TIMER_COMPARE = 2'd2;
  localparam logic [1:0] TIMER_STATUS  = 2'd3;

  localparam int CTRL_EN           = 0;
  localparam int CTRL_AUTO_RELOAD  = 1;
  localparam int CTRL_IE           = 2;
  localparam int CTRL_PRESCALE_LSB = 16;

  localparam int STATUS_MATCH = 0;
  localparam int STATUS_OVF   = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } bus_state_e;

  // Replace only the bytes whose write strobe is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  lanes);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - divides the bus clock into one tick every prescale+1 cycles
module timer_prescaler #(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      restart,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == prescale);

  always_comb begin
    cnt_d = cnt_q + PRESCALE_WIDTH'(1);
    if (!enable || restart || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/musb_timer.sv
// rtl/musb_timer.sv - memory-mapped 32-bit timer/compare slave with level match interrupt
module musb_timer
  import musb_timer_defines::*;
#(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  timer_address,
  input  logic [31:0] timer_data_i,
  input  logic [3:0]  timer_wr,
  input  logic        timer_enable,
  output logic [31:0] timer_data_o,
  output logic        timer_ready,
  output logic        timer_interrupt
);

  localparam logic [31:0] CTRL_MASK =
    (((32'd1 << PRESCALE_WIDTH) - 32'd1) << CTRL_PRESCALE_LSB) |
    (32'd1 << CTRL_EN) | (32'd1 << CTRL_AUTO_RELOAD) | (32'd1 << CTRL_IE);

  bus_state_e  state_q, state_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [1:0]  status_q, status_d;
  logic [31:0] rdata_q, rdata_d;

  logic [1:0]  reg_sel;
  logic        access, is_write;
  logic        wr_ctrl, wr_count, wr_compare, wr_status;
  logic        tick, match_hit, ovf_hit;
  logic [1:0]  status_set, status_clr;
  logic [31:0] rd_mux;
  logic        unused_addr_bits;

  assign reg_sel          = timer_address[3:2];
  assign unused_addr_bits = ^timer_address[1:0];

  // Accesses are only taken in IDLE, so a held enable yields one access every two cycles.
  assign access     = (state_q == IDLE) && timer_enable;
  assign is_write   = |timer_wr;
  assign wr_ctrl    = access && is_write && (reg_sel == TIMER_CTRL);
  assign wr_count   = access && is_write && (reg_sel == TIMER_COUNT);
  assign wr_compare = access && is_write && (reg_sel == TIMER_COMPARE);
  assign wr_status  = access && is_write && (reg_sel == TIMER_STATUS);

  timer_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .enable   (ctrl_q[CTRL_EN]),
    .prescale (ctrl_q[CTRL_PRESCALE_LSB +: PRESCALE_WIDTH]),
    .restart  (wr_ctrl && (|timer_wr[3:2])),
    .tick     (tick)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (timer_enable) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      TIMER_CTRL:    rd_mux = ctrl_q;
      TIMER_COUNT:   rd_mux = count_q;
      TIMER_COMPARE: rd_mux = compare_q;
      TIMER_STATUS:  rd_mux = {30'd0, status_q};
      default:       rd_mux = '0;
    endcase
  end

  always_comb begin
    match_hit = tick && (count_q == compare_q);
    ovf_hit   = tick && !match_hit && (count_q == 32'hFFFF_FFFF);

    count_d = count_q;
    if (tick) begin
      count_d = (match_hit && ctrl_q[CTRL_AUTO_RELOAD]) ? 32'd0 : count_q + 32'd1;
    end
    // A bus write to COUNT overrides whatever the tick would have produced.
    if (wr_count) count_d = byte_merge(count_q, timer_data_i, timer_wr);

    compare_d = compare_q;
    if (wr_compare) compare_d = byte_merge(compare_q, timer_data_i, timer_wr);

    ctrl_d = ctrl_q;
    if (wr_ctrl) ctrl_d = byte_merge(ctrl_q, timer_data_i, timer_wr) & CTRL_MASK;

    status_set               = '0;
    status_set[STATUS_MATCH] = match_hit;
    status_set[STATUS_OVF]   = ovf_hit;
    status_clr               = (wr_status && timer_wr[0]) ? timer_data_i[1:0] : 2'b00;
    // Set is applied after clear so a same-cycle hardware event is never lost.
    status_d = (status_q & ~status_clr) | status_set;

    rdata_d = rdata_q;
    if (access) rdata_d = is_write ? 32'd0 : rd_mux;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ctrl_q    <= '0;
      count_q   <= '0;
      compare_q <= '0;
      status_q  <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      status_q  <= status_d;
      rdata_q   <= rdata_d;
    end
  end

  assign timer_data_o    = rdata_q;
  assign timer_ready     = (state_q == RESP);
  assign timer_interrupt = ctrl_q[CTRL_IE] & status_q[STATUS_MATCH];

endmodule

// File: tb/tb_musb_timer.sv
// tb/tb_musb_timer.sv - scoreboard bench for musb_timer driven by directed and random bus traffic
`timescale 1ns/1ps
module tb_musb_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  addr = 4'h0;
  logic [3:0]  wr = 4'h0;
  logic [31:0] din = 32'h0;
  logic        en = 1'b0;
  logic [31:0] dout;
  logic        ready;
  logic        irq;

  musb_timer #(.PRESCALE_WIDTH(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .timer_address   (addr),
    .timer_data_i    (din),
    .timer_wr        (wr),
    .timer_enable    (en),
    .timer_data_o    (dout),
    .timer_ready     (ready),
    .timer_interrupt (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] sb_q[$];

  // Reference model: architectural register contents plus elapsed enabled cycles.
  bit              m_en = 0, m_ar = 0, m_ie = 0;
  int unsigned     m_presc = 0;
  logic [31:0]     m_count = 0, m_compare = 0, m_dout = 0;
  bit              m_match = 0, m_ovf = 0, m_busy = 0;
  longint unsigned m_elapsed = 0;

  function automatic void cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] l);
    logic [31:0] m;
    m = {{8{l[3]}}, {8{l[2]}}, {8{l[1]}}, {8{l[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] sel);
    logic [15:0] p;
    p = 16'(m_presc);
    case (sel)
      2'd0:    return {p, 13'd0, m_ie, m_ar, m_en};
      2'd1:    return m_count;
      2'd2:    return m_compare;
      default: return {30'd0, m_ovf, m_match};
    endcase
  endfunction

  task automatic model_reset();
    m_en = 0; m_ar = 0; m_ie = 0; m_presc = 0;
    m_count = 0; m_compare = 0; m_dout = 0;
    m_match = 0; m_ovf = 0; m_busy = 0; m_elapsed = 0;
    sb_q.delete();
  endtask

  task automatic model_edge();
    bit              tick, take, set_m, set_o;
    logic [31:0]     next_count, c, rv;
    longint unsigned next_elapsed;
    tick  = m_en && ((m_elapsed % (longint'(m_presc) + 1)) == longint'(m_presc));
    take  = en && !m_busy;
    set_m = 0;
    set_o = 0;
    next_count = m_count;
    if (tick) begin
      if (m_count == m_compare) begin
        set_m = 1;
        next_count = m_ar ? 32'd0 : m_count + 32'd1;
      end else begin
        set_o = (m_count == 32'hFFFF_FFFF);
        next_count = m_count + 32'd1;
      end
    end
    next_elapsed = m_en ? m_elapsed + 1 : 0;
    if (take) begin
      if (wr == 4'h0) begin
        rv = model_read(addr[3:2]);
        sb_q.push_back(rv);
        m_dout = rv;
      end else begin
        sb_q.push_back(32'd0);
        m_dout = 32'd0;
        case (addr[3:2])
          2'd0: begin
            c = lane_merge(model_read(2'd0), din, wr);
            m_en = c[0]; m_ar = c[1]; m_ie = c[2];
            m_presc = int'(c[31:16]);
            if (wr[2] || wr[3]) next_elapsed = 0;
          end
          2'd1: next_count = lane_merge(m_count, din, wr);
          2'd2: m_compare = lane_merge(m_compare, din, wr);
          default: if (wr[0]) begin
            if (din[0]) m_match = 0;
            if (din[1]) m_ovf = 0;
          end
        endcase
      end
    end
    if (set_m) m_match = 1;
    if (set_o) m_ovf = 1;
    m_count   = next_count;
    m_elapsed = next_elapsed;
    m_busy    = take;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_edge();
  end

  // Monitor: pops the scoreboard on every ready pulse and tracks idle outputs.
  always @(negedge clk) begin
    if (ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ready: got ready=1 expected no pending access at %0t", $time);
      end else begin
        cmp("read_data", dout, sb_q.pop_front());
      end
    end else begin
      cmp("data_hold", dout, m_dout);
    end
    cmp("ready", {31'd0, ready}, {31'd0, m_busy});
    cmp("irq", {31'd0, irq}, {31'd0, m_ie & m_match});
  end

  task automatic bus(input logic [3:0] a, input logic [3:0] w, input logic [31:0] d,
                     input int hold);
    @(negedge clk);
    addr = a; wr = w; din = d; en = 1'b1;
    repeat (hold) @(negedge clk);
    en = 1'b0; wr = 4'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] rand_data(input logic [1:0] sel);
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 2);
    case (sel)
      2'd0: r[31:16] = 16'($urandom_range(0, 4));
      2'd1, 2'd2: begin
        if (k == 0)      r = 32'($urandom_range(0, 24));
        else if (k == 1) r = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      end
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    logic [5:0]  pat;
    logic [1:0]  sel;
    logic [3:0]  w;
    int          kind;

    #1 rst = 1'b0;
    idle(3);
    rst = 1'b1;

    for (int i = 0; i < 4; i++) bus(4'(i * 4), 4'h0, 32'h0, 1);

    // Basic count with compare 5, interrupt, then W1C of MATCH.
    bus(4'h8, 4'hF, 32'd5, 1);
    bus(4'h0, 4'hF, 32'h0000_0005, 1);
    idle(8);
    bus(4'hC, 4'h0, 32'h0, 1);
    bus(4'h4, 4'h0, 32'h0, 1);
    bus(4'hC, 4'h1, 32'h1, 1);
    @(negedge clk);
    cmp("irq_after_w1c", {31'd0, irq}, 32'd0);

    // Prescale 3 with auto-reload at compare 2, COUNT read back-to-back.
    bus(4'h0, 4'hF, 32'h0, 1);
    bus(4'h4, 4'hF, 32'h0, 1);
    bus(4'hC, 4'hF, 32'h3, 1);
    bus(4'h8, 4'hF, 32'd2, 1);
    bus(4'h0, 4'hF, 32'h0003_0003, 1);
    bus(4'h4, 4'h0, 32'h0, 30);
    bus(4'hC, 4'h0, 32'h0, 1);

    // Overflow, then byte-lane clear of OVF only.
    bus(4'h0, 4'hF, 32'h0, 1);
    bus(4'hC, 4'hF, 32'h3, 1);
    bus(4'h4, 4'hF, 32'hFFFF_FFFF, 1);
    bus(4'h8, 4'hF, 32'h10, 1);
    bus(4'h0, 4'hF, 32'h1, 1);
    idle(3);
    bus(4'hC, 4'h0, 32'h0, 1);
    bus(4'h4, 4'h0, 32'h0, 1);
    bus(4'hC, 4'h1, 32'h2, 1);
    bus(4'hC, 4'h0, 32'h0, 1);

    // Collisions: COUNT write on a tick, W1C on the match tick.
    bus(4'h0, 4'hF, 32'h0, 1);
    bus(4'hC, 4'hF, 32'h3, 1);
    bus(4'h4, 4'hF, 32'h0, 1);
    bus(4'h8, 4'hF, 32'h200, 1);
    bus(4'h0, 4'hF, 32'h0000_0005, 1);
    bus(4'h4, 4'hF, 32'h100, 1);
    bus(4'h4, 4'h0, 32'h0, 1);
    bus(4'h4, 4'hF, 32'h1FF, 1);
    bus(4'hC, 4'h1, 32'h1, 1);
    cmp("w1c_vs_set", {31'd0, irq}, 32'd1);
    bus(4'hC, 4'h0, 32'h0, 1);

    // Handshake: enable held for six cycles gives ready on alternate cycles.
    @(negedge clk);
    addr = 4'h4; wr = 4'h0; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat[i] = ready;
    end
    en = 1'b0;
    cmp("ready_pattern", {26'd0, pat}, 32'h15);
    bus(4'h8, 4'hF, 32'h1122_3344, 1);
    bus(4'h8, 4'h4, 32'hAABB_CCDD, 1);
    bus(4'h8, 4'h0, 32'h0, 1);

    // Reset in the middle of a read with the interrupt asserted.
    bus(4'h0, 4'hF, 32'h0, 1);
    bus(4'hC, 4'hF, 32'h3, 1);
    bus(4'h4, 4'hF, 32'd3, 1);
    bus(4'h8, 4'hF, 32'd3, 1);
    bus(4'h0, 4'hF, 32'h0000_0005, 1);
    idle(2);
    @(negedge clk);
    addr = 4'h4; wr = 4'h0; en = 1'b1;
    @(posedge clk);
    #1;
    cmp("irq_before_reset", {31'd0, irq}, 32'd1);
    cmp("ready_before_reset", {31'd0, ready}, 32'd1);
    rst = 1'b0;
    en = 1'b0;
    #1;
    cmp("reset_ready", {31'd0, ready}, 32'd0);
    cmp("reset_irq", {31'd0, irq}, 32'd0);
    cmp("reset_dout", dout, 32'd0);
    idle(2);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) bus(4'(i * 4), 4'h0, 32'h0, 1);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      sel  = 2'($urandom_range(0, 3));
      kind = $urandom_range(0, 9);
      if (kind < 4)      w = 4'h0;
      else if (kind < 7) w = 4'hF;
      else               w = 4'($urandom_range(1, 15));
      bus({sel, 2'($urandom_range(0, 3))}, w, rand_data(sel), $urandom_range(1, 3));
      idle($urandom_range(0, 3));
    end

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending responses expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/musb_timer.md
# musb_timer

Memory-mapped 32-bit timer/compare peripheral, added as a fourth slave on the SoC bus downstream of the address-decoding mux switch (suggested window 0x1200_0000, mask 0xFFFF_FFF0). It consumes the switch's slave-side address/data/wr/enable signals and returns data/ready. It raises a level interrupt into the core's interrupt vector on a compare match. It provides the OS tick and delay timing the SoC currently lacks.

## Interface
- PRESCALE_WIDTH, 16: width of the prescaler field and counter.
- clk  in  1  bus clock (clk_bus domain).
- rst  in  1  asynchronous, active-low reset.
- timer_address  in  4  byte address within window; bits [3:2] select register, [1:0] ignored.
- timer_data_i  in  32  write data.
- timer_wr  in  4  byte-lane write strobes; 0000 = read.
- timer_enable  in  1  access request from mux switch.
- timer_data_o  out  32  read data, valid while timer_ready=1.
- timer_ready  out  1  one-cycle access-complete pulse.
- timer_interrupt  out  1  level interrupt = CTRL.IE & STATUS.MATCH.

## Operation
- Registers:
  - 0x0 CTRL: [0] EN, [1] AUTO_RELOAD, [2] IE, [16 +: PRESCALE_WIDTH] PRESCALE. Other bits read 0.
  - 0x4 COUNT: 32-bit counter, R/W.
  - 0x8 COMPARE: 32-bit, R/W.
  - 0xC STATUS: [0] MATCH, [1] OVF. Write-1-to-clear per bit.
- Byte writes: only lanes with timer_wr[n]=1 are updated. For STATUS, only lane 0 is meaningful.
- Prescaler: counts 0..PRESCALE while EN=1 and emits tick when prescaler==PRESCALE, then restarts at 0. PRESCALE=0 ticks every cycle. EN=0 holds the prescaler at 0 and suppresses ticks.
- On tick:
  - If COUNT==COMPARE: set MATCH. COUNT←0 if AUTO_RELOAD, else COUNT←COUNT+1.
  - Otherwise COUNT←COUNT+1, wrapping 0xFFFF_FFFF→0 and setting OVF on the wrap.
- Bus FSM states:
  - IDLE: timer_enable=1 → perform the access (write committed, read data registered) → RESP.
  - RESP: timer_ready=1 for exactly one cycle → IDLE.
  - timer_enable held high through RESP starts a new access in the following IDLE cycle; no access is taken in RESP.
- Simultaneous events:
  - A bus write to COUNT in the tick cycle wins; the increment is dropped.
  - A W1C to MATCH/OVF in the same cycle as a hardware set leaves the bit set.
  - A write to PRESCALE restarts the prescaler at 0.
  - A read of COUNT returns the pre-update value for that cycle.

## Timing
- Reset (rst=0, async): CTRL, COUNT, COMPARE, STATUS and prescaler = 0; FSM in IDLE; timer_data_o=0, timer_ready=0, timer_interrupt=0. Reset mid-access aborts it and ready never pulses.
- Access latency: enable sampled at edge N → ready=1 and data_o valid during cycle N+1 → ready=0 at N+2. Minimum 2 cycles per access.
- timer_data_o holds its last read value when ready=0 (writes return 0).
- COUNT update and MATCH set land on the same edge as the tick. timer_interrupt rises in the cycle after that edge: it is combinational from flopped bits, with no extra register.
- Tick period is PRESCALE+1 cycles. Setting EN=1 yields the first tick PRESCALE+1 cycles later.

## Structure
- Shared package/defines file `musb_timer_defines`: register offsets (TIMER_CTRL=2'd0, TIMER_COUNT=2'd1, TIMER_COMPARE=2'd2, TIMER_STATUS=2'd3), CTRL/STATUS bit indices, PRESCALE field LSB (16), and FSM state encodings (IDLE, RESP).
- One sub-module `timer_prescaler`: inputs clk, rst, enable, prescale, restart; output tick.
- All other logic (register file, counter, FSM) lives in the top module.

## Test plan
- Reset: drive rst=0 mid-read → ready, interrupt and data_o go 0 immediately. After release, all four registers read 0x0000_0000.
- Basic count: PRESCALE=0, COMPARE=5, EN=1, IE=1 → MATCH sets on the tick where COUNT==5, and COUNT becomes 6 (no AUTO_RELOAD). interrupt=1 one cycle later. Writing 0x1 to STATUS clears interrupt.
- Prescale + auto-reload: PRESCALE=3, COMPARE=2, AUTO_RELOAD=1 → COUNT sequence 0,1,2,0 with ticks every 4 cycles. MATCH sets every 12 cycles.
- Overflow: write COUNT=0xFFFF_FFFF, COMPARE=0x10, EN=1 → COUNT becomes 0 and OVF=1. Byte write wr=0001 with data 0x02 to STATUS clears only OVF.
- Collisions: write COUNT=0x100 on a tick cycle → COUNT reads 0x100. Issue a W1C to MATCH on a match tick → MATCH stays 1.
- Handshake: hold enable for back-to-back reads → ready pulses every 2nd cycle. Write with wr=0100 to COMPARE → only bits [23:16] change.
